// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, multi-cycle mult/div
// stall sequencing, deferred branch flush and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int R_WIDTH   = 5,
    parameter int MD_CYCLES = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [R_WIDTH-1:0]   rs_id_i,
    input  logic [R_WIDTH-1:0]   rt_id_i,
    input  logic                 id_uses_rt_i,
    input  logic                 mem_read_ex_i,
    input  logic [R_WIDTH-1:0]   rt_ex_i,
    input  logic                 md_start_i,
    input  logic                 branch_taken_i,
    output logic                 stall_if_o,
    output logic                 keep_idex_o,
    output logic                 bubble_idex_o,
    output logic                 flush_ifid_o,
    output logic                 md_busy_o,
    output logic                 md_done_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

    state_t                 state_q;
    logic [7:0]             md_cnt_q;
    logic                   pend_flush_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_d;
    logic                   pend_flush_d;
    logic                   load_use;
    logic                   md_busy;
    logic                   stall;

    assign load_use = mem_read_ex_i & (rt_ex_i != '0) &
                      ((rt_ex_i == rs_id_i) | (id_uses_rt_i & (rt_ex_i == rt_id_i)));

    assign md_busy = (state_q == S_BUSY) | ((state_q == S_IDLE) & md_start_i);
    assign stall   = md_busy | load_use;

    assign md_busy_o     = md_busy;
    assign md_done_o     = (state_q == S_DONE);
    assign stall_if_o    = stall;
    assign keep_idex_o   = md_busy;
    assign bubble_idex_o = ~md_busy & load_use;
    assign flush_ifid_o  = ~md_busy & (branch_taken_i | pend_flush_q);
    assign stall_cnt_o   = stall_cnt_q;

    // A branch resolved while the unit is busy is remembered until the
    // first free cycle, where flush_ifid_o fires and the flag drops.
    assign pend_flush_d = md_busy & (pend_flush_q | branch_taken_i);
    assign stall_cnt_d  = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // DONE is entered on the edge where the counter value becomes zero, so the
    // start edge plus the BUSY edges total MD_CYCLES-1 busy edges.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            md_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start_i) begin
                        md_cnt_q <= MD_LOAD;
                        state_q  <= (MD_LOAD == 8'd0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    md_cnt_q <= md_cnt_q - 8'd1;
                    if (md_cnt_q == 8'd1) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_flush_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pend_flush_q <= pend_flush_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus reset-abort and counter
// saturation sequences, checked through an expected-value queue.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b1;
    logic       rst_n_i;
    logic [4:0] rs_id_i, rt_id_i, rt_ex_i;
    logic       id_uses_rt_i, mem_read_ex_i, md_start_i, branch_taken_i;
    logic       stall_if_o, keep_idex_o, bubble_idex_o, flush_ifid_o;
    logic       md_busy_o, md_done_o;
    logic [3:0] stall_cnt_o;

    pipe_hazard_ctrl #(.R_WIDTH(5), .MD_CYCLES(4), .CNT_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rs_id_i(rs_id_i), .rt_id_i(rt_id_i), .id_uses_rt_i(id_uses_rt_i),
        .mem_read_ex_i(mem_read_ex_i), .rt_ex_i(rt_ex_i),
        .md_start_i(md_start_i), .branch_taken_i(branch_taken_i),
        .stall_if_o(stall_if_o), .keep_idex_o(keep_idex_o),
        .bubble_idex_o(bubble_idex_o), .flush_ifid_o(flush_ifid_o),
        .md_busy_o(md_busy_o), .md_done_o(md_done_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // {stall, keep, bubble, flush, busy, done, stall_cnt[3:0]}
    logic [9:0] obs;
    assign obs = {stall_if_o, keep_idex_o, bubble_idex_o, flush_ifid_o,
                  md_busy_o, md_done_o, stall_cnt_o};

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, mem_rd;
        logic [4:0] rt_ex;
        logic       start, br;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs[19];
    logic [9:0] sb_q[$];
    int         tests = 0;
    int         failed = 0;

    function automatic vec_t mk(input int rs, input int rt, input logic u, input logic m,
                                input int rtex, input logic s, input logic b,
                                input logic [5:0] flags, input int cnt);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u; v.mem_rd = m;
        v.rt_ex = 5'(rtex); v.start = s; v.br = b;
        v.exp = {flags, 4'(cnt)};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs_id_i = v.rs; rt_id_i = v.rt; id_uses_rt_i = v.uses_rt;
        mem_read_ex_i = v.mem_rd; rt_ex_i = v.rt_ex;
        md_start_i = v.start; branch_taken_i = v.br;
    endtask

    task automatic check(input string nm);
        logic [9:0] e;
        tests++;
        if (sb_q.size() == 0) begin
            failed++;
            $display("FAIL %s: no expected entry, got=%b", nm, obs);
        end else begin
            e = sb_q.pop_front();
            if (obs !== e) begin
                failed++;
                $display("FAIL %s: got=%b exp=%b", nm, obs, e);
            end
        end
    endtask

    vec_t idle_v, lu_v;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        lu_v   = mk(5, 0, 0, 1, 5, 0, 0, 6'b101000, 0);
        //               rs rt u  m  rtex s  b  stall/keep/bub/flush/busy/done cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        vecs[1]  = mk(5, 0, 0, 1, 5, 0, 0, 6'b101000, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 1);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 6'b000000, 1);
        vecs[4]  = mk(3, 5, 0, 1, 5, 0, 0, 6'b000000, 1);
        vecs[5]  = mk(3, 5, 1, 1, 5, 0, 0, 6'b101000, 1);
        vecs[6]  = mk(5, 0, 0, 0, 5, 0, 0, 6'b000000, 2);
        vecs[7]  = mk(5, 0, 0, 1, 5, 0, 1, 6'b101100, 2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 3);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 6'b110010, 3);
        vecs[10] = mk(5, 0, 0, 1, 5, 0, 1, 6'b110010, 4);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 6'b110010, 5);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000101, 6);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 6);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 6'b110010, 6);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 6'b110010, 7);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 6'b110010, 8);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 0, 6'b000001, 9);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 9);

        rst_n_i = 1'b0;
        drive(idle_v);
        sb_q.push_back(10'b0);
        #2 check("reset_state");
        @(posedge clk_i); rst_n_i = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(posedge clk_i);
            drive(vecs[i]);
            sb_q.push_back(vecs[i].exp);
            #2 check($sformatf("vec%0d", i));
        end

        // Reset on the second BUSY cycle aborts the operation.
        @(posedge clk_i); rst_n_i = 1'b0; drive(idle_v);
        @(posedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); md_start_i = 1'b1;
        sb_q.push_back({6'b110010, 4'd0});
        #2 check("abort_start");
        @(posedge clk_i); md_start_i = 1'b0;
        sb_q.push_back({6'b110010, 4'd1});
        #2 check("abort_busy1");
        @(posedge clk_i); rst_n_i = 1'b0; drive(lu_v);
        sb_q.push_back({6'b101000, 4'd0});
        #2 check("abort_rst_lu");
        @(posedge clk_i); drive(idle_v);
        sb_q.push_back(10'b0);
        #2 check("abort_rst_hold");
        @(posedge clk_i); rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(10'b0);
            #2 check($sformatf("abort_no_done%0d", i));
            @(posedge clk_i);
        end

        // Twenty continuous stall cycles saturate a 4-bit counter at 15.
        rst_n_i = 1'b0;
        @(posedge clk_i); rst_n_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); drive(lu_v);
        end
        @(posedge clk_i); drive(idle_v);
        sb_q.push_back({6'b000000, 4'd15});
        #2 check("sat_15");
        @(posedge clk_i);
        sb_q.push_back({6'b000000, 4'd15});
        #2 check("sat_hold");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter R_WIDTH, default 5, register-specifier width.
REQ-002 Parameter MD_CYCLES, default 32, EX-stage cycles occupied by a mult/div instruction, legal range 2..255.
REQ-003 Parameter CNT_WIDTH, default 16, stall statistics counter width.
REQ-004 clk_i  input  1  pipeline clock; all state updates on falling edge, same edge as pipeline registers.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 rs_id_i  input  R_WIDTH  rs field of the instruction in ID.
REQ-007 rt_id_i  input  R_WIDTH  rt field of the instruction in ID.
REQ-008 id_uses_rt_i  input  1  ID instruction reads rt as a source.
REQ-009 mem_read_ex_i  input  1  instruction in EX is a load.
REQ-010 rt_ex_i  input  R_WIDTH  destination rt of the instruction in EX.
REQ-011 md_start_i  input  1  instruction in EX is mult/div.
REQ-012 branch_taken_i  input  1  branch resolved taken this cycle.
REQ-013 stall_if_o  output  1  hold PC and IF/ID register.
REQ-014 keep_idex_o  output  1  drives ID/EX keep input (hold contents).
REQ-015 bubble_idex_o  output  1  zero WB/MEM/EX control fields entering ID/EX.
REQ-016 flush_ifid_o  output  1  invalidate the IF/ID instruction.
REQ-017 md_busy_o  output  1  mult/div unit occupied.
REQ-018 md_done_o  output  1  one-cycle pulse, mult/div result valid.
REQ-019 stall_cnt_o  output  CNT_WIDTH  total stall cycles since reset.

Function
REQ-020 Load-use hazard LU = mem_read_ex_i & (rt_ex_i != 0) & ((rt_ex_i == rs_id_i) | (id_uses_rt_i & (rt_ex_i == rt_id_i))), combinational.
REQ-021 FSM states IDLE, BUSY, DONE; encoding free.
REQ-022 IDLE: md_start_i=1 -> BUSY, down-counter loaded MD_CYCLES-2.
REQ-023 BUSY: counter decrements each edge; counter==0 at edge -> DONE.
REQ-024 DONE: unconditionally -> IDLE next edge; md_start_i ignored in DONE.
REQ-025 md_busy_o = 1 in BUSY and in IDLE while md_start_i=1; md_done_o = 1 only in DONE.
REQ-026 Total mult/div occupancy: md_start_i sampled in IDLE -> exactly MD_CYCLES-1 busy edges, then one DONE cycle.
REQ-027 md_busy_o=1 -> stall_if_o=1, keep_idex_o=1, bubble_idex_o=0.
REQ-028 md_busy_o=0 and LU=1 -> stall_if_o=1, bubble_idex_o=1, keep_idex_o=0 (exactly one bubble per hazard).
REQ-029 Otherwise stall_if_o, keep_idex_o, bubble_idex_o = 0.
REQ-030 branch_taken_i=1 with md_busy_o=0 -> flush_ifid_o=1 same cycle.
REQ-031 branch_taken_i=1 with md_busy_o=1 -> pending-flush flag set; flush_ifid_o=1 in first cycle with md_busy_o=0; flag cleared at that edge.
REQ-032 Flush and load-use bubble same cycle -> both asserted; flush has no effect on stall outputs.
REQ-033 stall_cnt_o increments on each edge where stall_if_o=1; saturates at all-ones, no wrap.
REQ-034 All outputs glitch-free functions of registered state plus current inputs; no combinational loop through keep/bubble.

Reset
REQ-035 rst_n_i=0 -> immediately: FSM IDLE, down-counter 0, pending-flush 0, stall_cnt_o 0, md_done_o 0.
REQ-036 Reset mid-BUSY aborts operation; no md_done_o pulse follows; rst_n_i release needs no clock.
REQ-037 Outputs during reset reflect IDLE with current inputs (LU-only stalls possible).

Verification
REQ-038 Load r5 in EX (rt_ex=5, mem_read=1), ID rs=5 -> stall_if=1, bubble=1 one cycle; stall_cnt 0->1.
REQ-039 Same with rt_ex=0 -> no stall; with rt_id=5, id_uses_rt=0 -> no stall.
REQ-040 MD_CYCLES=4, md_start pulse -> keep_idex/stall_if high 3 edges, md_done pulse next cycle, stall_cnt=3.
REQ-041 branch_taken during BUSY -> flush_ifid deferred to first non-busy cycle, asserted exactly once.
REQ-042 Reset asserted on 2nd BUSY cycle -> all stalls drop immediately except LU, FSM IDLE, no md_done, stall_cnt 0.
REQ-043 CNT_WIDTH=4, 20 continuous stall cycles -> stall_cnt_o holds 15.
